// File: rtl/shift_seq_reg_if.sv
// shift_seq_reg_if: control/data bundle between the multiplier controller and the shift register
interface shift_seq_reg_if #(
    parameter int N = 8
);
    localparam int CW = $clog2(N + 1);
    logic          clear;
    logic          load;
    logic          shift;
    logic          dir;
    logic [1:0]    mode;
    logic          ser_in;
    logic [N-1:0]  d_in;
    logic          start;
    logic [CW-1:0] count;
    logic [N-1:0]  d_out;
    logic          ser_out;
    logic          busy;
    logic          done;
    modport master (
        output clear, load, shift, dir, mode, ser_in, d_in, start, count,
        input  d_out, ser_out, busy, done
    );
    modport slave (
        input  clear, load, shift, dir, mode, ser_in, d_in, start, count,
        output d_out, ser_out, busy, done
    );
endinterface

// File: rtl/shift_seq_reg.sv
// shift_seq_reg: universal N-bit shift register with an autonomous count-driven shift sequencer
module shift_seq_reg #(
    parameter int N = 8
) (
    input logic           clk,
    input logic           rst,
    shift_seq_reg_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] N_MAX = CW'(N);
    typedef enum logic {IDLE, RUN} state_t;
    state_t        state_q, state_d;
    logic [N-1:0]  reg_q, reg_d;
    logic [CW-1:0] rem_q, rem_d;
    logic          done_q, done_d;
    logic [CW-1:0] count_sat;
    function automatic logic [N-1:0] step(input logic [N-1:0] r, input logic dir,
                                          input logic [1:0] mode, input logic si);
        logic fill_r, fill_l;
        fill_r = (mode == 2'b01) ? r[0]   : (mode == 2'b10) ? r[N-1] : si;
        fill_l = (mode == 2'b01) ? r[N-1] : (mode == 2'b10) ? 1'b0   : si;
        return dir ? {r[N-2:0], fill_l} : {fill_r, r[N-1:1]};
    endfunction
    assign count_sat = (bus.count > N_MAX) ? N_MAX : bus.count;
    // state register: async reset clears the datapath and any sequence in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            reg_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end
    // next state: clear wins, then IDLE manual/start handling or one RUN step per cycle
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        if (bus.clear) begin
            state_d = IDLE;
            reg_d   = '0;
            rem_d   = '0;
        end else if (state_q == IDLE) begin
            if (bus.start) begin
                reg_d   = bus.d_in;
                rem_d   = count_sat;
                state_d = (count_sat != '0) ? RUN : IDLE;
                done_d  = (count_sat == '0);
            end else if (bus.load) begin
                reg_d = bus.shift ? step(bus.d_in, bus.dir, bus.mode, bus.ser_in) : bus.d_in;
            end else if (bus.shift) begin
                reg_d = step(reg_q, bus.dir, bus.mode, bus.ser_in);
            end
        end else begin
            reg_d   = step(reg_q, bus.dir, bus.mode, bus.ser_in);
            rem_d   = rem_q - CW'(1);
            state_d = (rem_q == CW'(1)) ? IDLE : RUN;
            done_d  = (rem_q == CW'(1));
        end
    end
    // outputs: busy tracks RUN, ser_out is the bit the next shift would eject
    always_comb begin
        bus.d_out   = reg_q;
        bus.ser_out = bus.dir ? reg_q[N-1] : reg_q[0];
        bus.busy    = (state_q == RUN);
        bus.done    = done_q;
    end
endmodule

// File: tb/tb_shift_seq_reg.sv
// tb_shift_seq_reg: scoreboard bench for manual ops, auto sequences and abort paths
module tb_shift_seq_reg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] dq[$];
    logic       sq[$];
    shift_seq_reg_if #(.N(8)) bus ();
    shift_seq_reg #(.N(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic manual(input string tag, input logic ld, input logic sh, input logic [7:0] d,
                          input logic si, input logic [7:0] exp);
        bus.load = ld; bus.shift = sh; bus.d_in = d; bus.ser_in = si;
        dq.push_back(exp);
        tick();
        bus.load = 1'b0; bus.shift = 1'b0;
        check(tag, bus.d_out, dq.pop_front());
    endtask
    task automatic auto_run(input string tag, input logic [7:0] d, input logic [3:0] cnt,
                            input logic dr, input logic [1:0] md, input logic si,
                            input int exp_busy, input logic poke);
        int  busy_n = 0;
        int  done_n = 0;
        bit  seen = 0;
        bus.d_in = d; bus.count = cnt; bus.dir = dr; bus.mode = md; bus.ser_in = si;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (dq.size() != 0) check({tag, "_dout"}, bus.d_out, dq.pop_front());
            if (bus.busy) begin
                busy_n++;
                if (sq.size() != 0) check({tag, "_serout"}, bus.ser_out, sq.pop_front());
            end
            if (bus.done) begin
                done_n++;
                seen = 1;
            end else begin
                if (poke) begin
                    bus.start = (k == 3); bus.load = (k == 3); bus.d_in = 8'h55;
                end
                tick();
            end
        end
        bus.start = 1'b0; bus.load = 1'b0;
        check({tag, "_done_n"}, done_n, 1);
        check({tag, "_busy_n"}, busy_n, exp_busy);
        check({tag, "_drained"}, dq.size() + sq.size(), 0);
        tick();
        check({tag, "_done_pulse"}, bus.done, 1'b0);
    endtask
    initial begin
        bus.clear = 0; bus.load = 0; bus.shift = 0; bus.dir = 0; bus.mode = 2'b00;
        bus.ser_in = 0; bus.d_in = '0; bus.start = 0; bus.count = '0;
        tick();
        tick();
        check("rst_dout", bus.d_out, 8'h00);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        rst = 1'b0;
        tick();
        manual("load", 1, 0, 8'hA5, 0, 8'hA5);
        manual("shift", 0, 1, 8'h00, 1, 8'hD2);
        manual("load_shift", 1, 1, 8'hA5, 0, 8'h52);
        manual("hold", 0, 0, 8'hFF, 1, 8'h52);
        dq = '{8'h90, 8'hC8, 8'hE4, 8'hF2};
        auto_run("arith_r", 8'h90, 4'd3, 1'b0, 2'b10, 1'b0, 3, 1'b0);
        dq = '{8'h3C, 8'h78, 8'hF0, 8'hE1, 8'hC3};
        sq = '{1'b0, 1'b0, 1'b1, 1'b1};
        auto_run("rot_l", 8'h3C, 4'd4, 1'b1, 2'b01, 1'b0, 4, 1'b0);
        dq = '{8'h5A};
        auto_run("cnt0", 8'h5A, 4'd0, 1'b0, 2'b00, 1'b0, 0, 1'b0);
        dq = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        auto_run("sat_l", 8'hFF, 4'd12, 1'b1, 2'b00, 1'b0, 8, 1'b1);
        bus.d_in = 8'hFF; bus.count = 4'd4; bus.dir = 0; bus.mode = 2'b00; bus.ser_in = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("clr_pre_dout", bus.d_out, 8'h3F);
        check("clr_pre_busy", bus.busy, 1'b1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clr_dout", bus.d_out, 8'h00);
        check("clr_busy", bus.busy, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("clr_no_done", bus.done, 1'b0);
            tick();
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_dout", bus.d_out, 8'h00);
        check("arst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("arst_no_done", bus.done, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
